// File: rtl/fifo_rr_push_arb_if.sv
// Bundle between a set of requesters and the shared FIFO push port, plus the
// arbiter's registered state exported for observation.
interface fifo_rr_push_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8
) ();
    // Handshake: req[i] is requester i's valid and gnt[i] its ready; a word moves
    // only in a cycle where both are high, and req/data must hold until then.
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          full;
    logic                          push;
    logic [FIFO_WIDTH-1:0]         push_data;
    logic [2:0]                    grant_id;
    logic [15:0]                   grant_cnt;
    logic                          dbg_state;      // 1 = BURST, 0 = IDLE
    logic [2:0]                    dbg_owner;
    logic [3:0]                    dbg_burst_cnt;

    modport master (
        output req, req_data, full,
        input  gnt, push, push_data, grant_id, grant_cnt,
               dbg_state, dbg_owner, dbg_burst_cnt
    );

    modport slave (
        input  req, req_data, full,
        output gnt, push, push_data, grant_id, grant_cnt,
               dbg_state, dbg_owner, dbg_burst_cnt
    );
endinterface

// File: rtl/fifo_rr_push_arb.sv
// Round-robin arbiter merging NUM_REQ requesters onto one FIFO push port, with
// bounded bursts to the current owner and a zero-latency combinational grant.
module fifo_rr_push_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int BURST_LEN  = 2
) (
    input  logic               clk,
    input  logic               rstn,
    fifo_rr_push_arb_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [2:0]  owner, owner_nxt;
    logic [3:0]  burst_cnt, burst_nxt;
    logic [15:0] grant_cnt;

    logic [7:0]            req_pad;
    logic [FIFO_WIDTH-1:0] data_arr [8];
    logic                  any_req;
    logic                  others_req;
    logic                  keep_owner;
    logic [2:0]            search_idx;
    logic [2:0]            grant_idx;
    logic                  push_int;

    assign req_pad = 8'(bus.req);

    for (genvar i = 0; i < 8; i++) begin : g_data
        if (i < NUM_REQ) begin : g_real
            assign data_arr[i] = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end else begin : g_absent
            assign data_arr[i] = '0;
        end
    end

    assign any_req    = |req_pad;
    assign others_req = |(req_pad & ~(8'd1 << owner));
    assign keep_owner = (state == BURST) && req_pad[owner] &&
                        ((burst_cnt < 4'(BURST_LEN)) || !others_req);

    // Cyclic search from owner+1; the owner itself is the last candidate.
    always_comb begin : arb_search
        logic       hit;
        logic [3:0] cand;
        hit        = 1'b0;
        cand       = '0;
        search_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, owner} + 4'(k);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            if (!hit && req_pad[cand[2:0]]) begin
                hit        = 1'b1;
                search_idx = cand[2:0];
            end
        end
    end

    assign grant_idx = keep_owner ? owner : search_idx;
    assign push_int  = rstn && any_req && !bus.full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= 3'(NUM_REQ - 1);
            burst_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            if (push_int) grant_cnt <= grant_cnt + 16'd1;
        end
    end

    // A blocked cycle (full with requests pending) leaves everything untouched.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        if (!any_req) begin
            state_nxt = IDLE;
            burst_nxt = '0;
        end else if (!bus.full) begin
            state_nxt = BURST;
            owner_nxt = grant_idx;
            if (grant_idx == owner) begin
                burst_nxt = (burst_cnt >= 4'(BURST_LEN)) ? 4'(BURST_LEN)
                                                         : burst_cnt + 4'd1;
            end else begin
                burst_nxt = 4'd1;
            end
        end
    end

    always_comb begin
        bus.push      = push_int;
        bus.grant_id  = push_int ? grant_idx : 3'd0;
        bus.push_data = push_int ? data_arr[grant_idx] : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.gnt[i] = push_int && (grant_idx == 3'(i));
        end
    end

    assign bus.grant_cnt     = grant_cnt;
    assign bus.dbg_state     = (state == BURST);
    assign bus.dbg_owner     = owner;
    assign bus.dbg_burst_cnt = burst_cnt;
endmodule

// File: tb/tb_fifo_rr_push_arb.sv
// Directed and random checks of fifo_rr_push_arb against an independent
// round-robin reference model feeding an expected-result queue.
module tb_fifo_rr_push_arb;
  localparam int NR = 4;
  localparam int FW = 8;
  localparam int BL = 2;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_rr_push_arb_if #(.NUM_REQ(NR), .FIFO_WIDTH(FW)) bif ();

  fifo_rr_push_arb #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .BURST_LEN(BL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif.slave)
  );

  // scoreboard: {push, grant_id, push_data}
  logic [11:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // reference model state
  int          m_owner = NR - 1;
  int          m_burst = 0;
  logic        m_busy  = 1'b0;
  logic [15:0] m_cnt   = '0;

  logic [FW-1:0] d [NR];
  logic [2:0]    last_id;
  logic          last_push;
  logic [3:0]    last_gnt;
  logic [FW-1:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    bif.req_data = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic model_step(input logic [3:0] r, input logic f, input logic rst_n,
                            output logic [11:0] e);
    int          g;
    logic [3:0]  oth;
    logic        keep;
    logic        found;
    e = '0;
    if (!rst_n) begin
      m_owner = NR - 1;
      m_burst = 0;
      m_busy  = 1'b0;
      m_cnt   = '0;
    end else if (r == 4'b0000) begin
      m_busy  = 1'b0;
      m_burst = 0;
    end else if (!f) begin
      oth = r;
      oth[m_owner] = 1'b0;
      keep = m_busy && r[m_owner] && ((m_burst < BL) || (oth == 4'b0000));
      g = m_owner;
      if (!keep) begin
        found = 1'b0;
        for (int j = 1; j <= NR; j++) begin
          if (!found && r[(m_owner + j) % NR]) begin
            found = 1'b1;
            g = (m_owner + j) % NR;
          end
        end
      end
      if (g == m_owner) m_burst = (m_burst < BL) ? m_burst + 1 : BL;
      else              m_burst = 1;
      m_owner = g;
      m_busy  = 1'b1;
      m_cnt   = m_cnt + 16'd1;
      e = {1'b1, 3'(g), d[g]};
    end
  endtask

  // driver: one cycle of stimulus, starting and ending 1 time unit after posedge
  task automatic tick(input logic [3:0] r, input logic f, input logic rst_n);
    logic [11:0] e;
    logic [11:0] o;
    logic [3:0]  eg;
    int          gid;
    bif.req  = r;
    bif.full = f;
    rstn     = rst_n;
    @(negedge clk);
    chk("grant_cnt", 32'(bif.grant_cnt), 32'(m_cnt));
    chk("state", 32'(bif.dbg_state), 32'(m_busy));
    chk("owner", 32'(bif.dbg_owner), 32'(m_owner));
    chk("burst_cnt", 32'(bif.dbg_burst_cnt), 32'(m_burst));
    model_step(r, f, rst_n, e);
    exp_q.push_back(e);
    e  = exp_q.pop_front();
    o  = {bif.push, bif.grant_id, bif.push_data};
    eg = e[11] ? (4'd1 << e[10:8]) : 4'd0;
    chk("push_id_data", 32'(o), 32'(e));
    chk("gnt", 32'(bif.gnt), 32'(eg));
    last_id   = bif.grant_id;
    last_push = bif.push;
    last_gnt  = bif.gnt;
    last_data = bif.push_data;
    @(posedge clk);
    #1;
    if (e[11]) begin
      gid    = int'(e[10:8]);
      d[gid] = FW'($urandom_range(0, 255));
      drive_data();
    end
  endtask

  int            seq030 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  logic [FW-1:0] d2;

  initial begin
    for (int i = 0; i < NR; i++) d[i] = FW'($urandom_range(0, 255));
    drive_data();
    bif.req  = '0;
    bif.full = 1'b0;
    rstn     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset forces outputs low regardless of req/full
    tick(4'b1111, 1'b0, 1'b0);
    chk("rst_push", 32'(last_push), 32'd0);
    tick(4'b1010, 1'b1, 1'b0);
    chk("rst_cnt", 32'(bif.grant_cnt), 32'd0);
    chk("rst_owner", 32'(bif.dbg_owner), 32'(NR - 1));

    // all requesting: pairs of grants rotating 0..3
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, 1'b0, 1'b1);
      chk("rr_seq", 32'(last_id), 32'(seq030[i]));
    end
    chk("cnt8", 32'(bif.grant_cnt), 32'd8);

    // single requester 2: granted every cycle, burst saturates at BURST_LEN
    tick(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d2 = bif.req_data[23:16];
      tick(4'b0100, 1'b0, 1'b1);
      chk("solo_gnt", 32'(last_gnt), 32'h4);
      chk("solo_data", 32'(last_data), 32'(d2));
      chk("solo_burst", 32'(bif.dbg_burst_cnt), (i == 0) ? 32'd1 : 32'd2);
    end

    // full blocks pushes and freezes the count
    repeat (3) begin
      tick(4'b0011, 1'b1, 1'b1);
      chk("full_push", 32'(last_push), 32'd0);
    end
    chk("full_cnt", 32'(bif.grant_cnt), 32'd13);
    tick(4'b0011, 1'b0, 1'b1);
    chk("unfull_id", 32'(last_id), 32'd0);

    // owner 1 burst 1, idle cycle, then search from 2 wraps to 0
    tick(4'b0010, 1'b0, 1'b1);
    chk("own1", 32'(bif.dbg_owner), 32'd1);
    tick(4'b0000, 1'b0, 1'b1);
    chk("idle_state", 32'(bif.dbg_state), 32'd0);
    chk("idle_burst", 32'(bif.dbg_burst_cnt), 32'd0);
    tick(4'b0011, 1'b0, 1'b1);
    chk("wrap_id", 32'(last_id), 32'd0);
    chk("wrap_burst", 32'(bif.dbg_burst_cnt), 32'd1);

    // reset mid-burst of owner 2
    tick(4'b0100, 1'b0, 1'b1);
    chk("own2", 32'(last_id), 32'd2);
    tick(4'b1111, 1'b0, 1'b0);
    chk("midrst_push", 32'(last_push), 32'd0);
    tick(4'b1111, 1'b0, 1'b1);
    chk("postrst_id", 32'(last_id), 32'd0);
    chk("postrst_cnt", 32'(bif.grant_cnt), 32'd1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      tick(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 40) != 0));
    end

    // grant_cnt wrap
    tick(4'b0000, 1'b0, 1'b0);
    bif.req  = 4'b0001;
    bif.full = 1'b0;
    rstn     = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", 32'(bif.grant_cnt), 32'h0000ffff);
    @(posedge clk);
    #1;
    chk("cnt_wrap", 32'(bif.grant_cnt), 32'h00000000);
    bif.req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_rr_push_arb.md
FIFO_RR_PUSH_ARB -- requirements
Module: fifo_rr_push_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FIFO push port (legal 2..8).
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 8, data width of each requester and of the FIFO (legal 8..11).
REQ-003 The block SHALL have parameter BURST_LEN, default 2, maximum consecutive grants to one requester while another requester waits (legal 1..15).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous and active-low.
REQ-006 req  input  NUM_REQ  per-requester request; bit i held high with stable data until granted.
REQ-007 req_data  input  NUM_REQ*FIFO_WIDTH  requester i data on bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 gnt  output  NUM_REQ  one-hot grant; gnt[i]=1 means req_data of i is written into the FIFO this cycle.
REQ-009 full  input  1  FIFO full flag.
REQ-010 push  output  1  FIFO push strobe.
REQ-011 push_data  output  FIFO_WIDTH  FIFO write data.
REQ-012 grant_id  output  3  index of the requester granted this cycle; 0 when push=0.
REQ-013 grant_cnt  output  16  registered count of total grants, wraps 0xFFFF->0x0000.

Function
REQ-014 Arbitration SHALL be combinational from req, full and registered state; gnt, push, push_data, grant_id SHALL be valid in the same cycle as req (zero latency).
REQ-015 push SHALL equal (|req) & ~full; gnt SHALL be all-zero whenever push=0; gnt SHALL have at most one bit set.
REQ-016 push_data SHALL equal req_data slice of the granted requester when push=1, and all-zero otherwise.
REQ-017 Registered state: FSM {IDLE, BURST}, owner pointer (last granted index), burst_cnt (4 bit).
REQ-018 In IDLE, the granted requester SHALL be the first requesting index found searching cyclically from owner+1 (mod NUM_REQ).
REQ-019 In BURST, owner SHALL be granted again if req[owner]=1 and (burst_cnt < BURST_LEN or no other req bit set); otherwise the cyclic search from owner+1 applies.
REQ-020 On a grant to a new index: owner <= that index, burst_cnt <= 1, state <= BURST.
REQ-021 On a grant to the same owner: burst_cnt <= min(burst_cnt+1, BURST_LEN), state stays BURST.
REQ-022 Cycle with |req=0: state <= IDLE, burst_cnt <= 0, owner unchanged.
REQ-023 Cycle with |req=1 and full=1: no grant; state, owner, burst_cnt, grant_cnt SHALL all hold.
REQ-024 grant_cnt SHALL increment by 1 on every cycle with push=1.
REQ-025 Requester data is consumed only in the gnt cycle; deasserting req without gnt is legal and SHALL leave no side effect.
REQ-026 Requester bits at index >= NUM_REQ do not exist; grant_id SHALL never exceed NUM_REQ-1.

Reset
REQ-027 While rstn=0 at a rising edge: state <= IDLE, owner <= NUM_REQ-1, burst_cnt <= 0, grant_cnt <= 0.
REQ-028 During the reset cycle gnt, push, push_data, grant_id SHALL be forced to 0 regardless of req/full.
REQ-029 Reset asserted mid-burst SHALL abort the burst; first grant after release SHALL go to the lowest requesting index (search from 0).

Verification
REQ-030 After reset, req=4'b1111, full=0, BURST_LEN=2 for 8 cycles -> grant_id sequence 0,0,1,1,2,2,3,3; grant_cnt=8.
REQ-031 req=4'b0100 only, 5 cycles -> gnt[2] every cycle, burst_cnt saturates at 2, push_data equals req_data[23:16].
REQ-032 req=4'b0011 with full=1 for 3 cycles then full=0 -> no push for 3 cycles, grant_cnt unchanged, then grant to index 0.
REQ-033 Owner 1 with burst_cnt=1, req drops to 0 for one cycle, then req=4'b0011 -> state IDLE, next grant to index 0 (search from 2 wraps to 0), burst_cnt=1.
REQ-034 grant_cnt preloaded by 65535 pushes, one more push -> grant_cnt=0x0000.
REQ-035 rstn=0 for one cycle during burst of owner 2 with req=4'b1111 -> outputs zero that cycle, next grant to index 0, grant_cnt=1.
